imm_operand_pipe: RTL
=====================

Name: imm_operand_pipe

Overview:
Registered, parametrised immediate generator for the decode stage of the pipelined RISC-V core. It generalises immediate extraction to XLEN 32 or 64 and adds CSR zimm and shift-amount types. Results travel with a caller tag through a valid/ready output register, with an optional skid buffer. It sits between IF/ID instruction delivery and the ID/EX register, and accepts flush from the hazard unit.

Parameters:
XLEN, 32, immediate output width; legal values are 32 and 64 only.
TAG_W, 8, width of the opaque tag carried with each immediate (e.g. PC index/ROB id).
SKID, 0, 0 = single output register; 1 = add a one-entry skid buffer so in_ready is a registered signal.

Ports:
CPU_CLK  input  1  clock, all state on rising edge
CPU_RST_N  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held entries
in_valid  input  1  instruction fields valid
in_ready  output  1  block can accept this cycle
in_instr  input  25  instruction bits [31:7]; in_instr[k-7] holds instr bit k
in_type  input  3  0 RTYPE, 1 ITYPE, 2 STYPE, 3 BTYPE, 4 UTYPE, 5 JTYPE, 6 ZTYPE, 7 SHTYPE
in_tag  input  TAG_W  caller tag
out_valid  output  1  out_imm/out_tag valid
out_ready  input  1  consumer accepts
out_imm  output  XLEN  immediate
out_tag  output  TAG_W  tag of out_imm
out_type  output  3  type of out_imm

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_imm=0, out_tag=0, out_type=0, skid empty. in_ready=1 from the first cycle after release.
- Immediate formation, sign bit is instr[31]; sign-extend to XLEN:
  ITYPE: sext(instr[31:20]).
  STYPE: sext({instr[31:25],instr[11:7]}).
  BTYPE: sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
  UTYPE: sext({instr[31:12],12'b0}), so bits 63:32 copy bit 31 when XLEN=64.
  JTYPE: sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
  RTYPE: 0.
  ZTYPE: zero-extended instr[19:15].
  SHTYPE: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
- Handshake: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready. out_imm/out_tag/out_type hold stable while out_valid&!out_ready. Latency is 1 cycle from input transfer to out_valid when the output register is free.
- SKID=0: in_ready = !out_valid | out_ready (combinational). Simultaneous in/out transfer reloads the register; out_valid stays 1 and there is no bubble.
- SKID=1: in_ready = skid empty (registered).
  - Input arrives while output is held and not accepted: capture into skid, in_ready drops next cycle.
  - Output accepted while skid full: skid moves to output, skid empties.
  - Never more than 2 entries. Order is preserved.
- flush: next edge out_valid=0 and skid emptied. An input presented in the same cycle as flush is discarded. Flush has priority over every transfer. out_imm is not required to clear.
- in_type is 3 bits and every code is defined, so there is no illegal case.
- XLEN other than 32/64: elaboration-time error ($error in generate).

Test Plan:
- XLEN=32, ITYPE, instr=0xFFF00093 (in_instr=instr[31:7]), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF; in_ready stays 1.
- XLEN=64, UTYPE, instr=0x800002B7 -> out_imm=0xFFFFFFFF80000000. JTYPE instr=0x0040006F -> out_imm=4. BTYPE instr=0xFE000EE3 -> out_imm=-4 (0xFFFF...FFFC).
- XLEN=32, ZTYPE instr=0x3401D073 -> out_imm=3. XLEN=64, SHTYPE instr=0x03F51513 -> out_imm=63. XLEN=32 with the same instr -> out_imm=31.
- SKID=1, out_ready=0, three back-to-back inputs tagged 1,2,3:
  - Tags 1 and 2 are held; in_ready=0 after the second transfer; tag 3 waits.
  - Raise out_ready -> outputs in order 1,2,3 with no loss or duplication.
  - Repeat with SKID=0: only 1 entry is held, then in_ready=0.
- Both entries full (SKID=1), assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
- Assert CPU_RST_N=0 mid-stream between clock edges -> out_valid drops immediately with no edge needed. After release, the first accepted input emerges correctly 1 cycle later.

Source files
------------

// File: rtl/imm_operand_pipe.sv
// imm_operand_pipe
// Decode-stage immediate generator. The immediate for the selected instruction
// format is formed from instruction bits [31:7] and sign/zero-extended to XLEN.
// The result travels with a caller tag through a valid/ready output register.
// An optional one-entry skid buffer makes in_ready a registered signal.
// flush kills every held entry and any input presented in the same cycle.
module imm_operand_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int SKID  = 0
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST_N,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_type
);

  localparam logic [2:0] TYPE_R  = 3'd0;
  localparam logic [2:0] TYPE_I  = 3'd1;
  localparam logic [2:0] TYPE_S  = 3'd2;
  localparam logic [2:0] TYPE_B  = 3'd3;
  localparam logic [2:0] TYPE_U  = 3'd4;
  localparam logic [2:0] TYPE_J  = 3'd5;
  localparam logic [2:0] TYPE_Z  = 3'd6;
  localparam logic [2:0] TYPE_SH = 3'd7;

  // Only RV32 and RV64 immediates are meaningful.
  if ((XLEN != 32'd32) && (XLEN != 32'd64)) begin : g_xlen_bad
    $error("imm_operand_pipe: XLEN must be 32 or 64");
  end

  // Builds the 64-bit extended immediate, then keeps the low XLEN bits.
  // The argument is indexed with real instruction bit numbers [31:7].
  function automatic logic [XLEN-1:0] form_imm(input logic [31:7] ins,
                                               input logic [2:0]  typ);
    logic [63:0] imm64;
    logic        s;
    s = ins[31];
    case (typ)
      TYPE_R:  imm64 = 64'd0;
      TYPE_I:  imm64 = {{52{s}}, ins[31:20]};
      TYPE_S:  imm64 = {{52{s}}, ins[31:25], ins[11:7]};
      TYPE_B:  imm64 = {{51{s}}, s, ins[7], ins[30:25], ins[11:8], 1'b0};
      TYPE_U:  imm64 = {{32{s}}, ins[31:12], 12'd0};
      TYPE_J:  imm64 = {{43{s}}, s, ins[19:12], ins[20], ins[30:21], 1'b0};
      TYPE_Z:  imm64 = {59'd0, ins[19:15]};
      TYPE_SH: imm64 = (XLEN == 32'd32) ? {59'd0, ins[24:20]} : {58'd0, ins[25:20]};
      default: imm64 = 64'd0;
    endcase
    return imm64[XLEN-1:0];
  endfunction

  logic             in_ready_s;
  logic             in_fire_s;
  logic [XLEN-1:0]  new_imm_s;
  logic             out_valid_r;
  logic [XLEN-1:0]  out_imm_r;
  logic [TAG_W-1:0] out_tag_r;
  logic [2:0]       out_type_r;

  assign in_fire_s = in_valid & in_ready_s;
  assign new_imm_s = form_imm(in_instr, in_type);

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_imm   = out_imm_r;
  assign out_tag   = out_tag_r;
  assign out_type  = out_type_r;

  if (SKID == 0) begin : g_noskid
    // The single register can load whenever it is empty or being drained.
    assign in_ready_s = ~out_valid_r | out_ready;

    // Output register: reload on input transfer, clear valid on drain.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
      if (!CPU_RST_N) begin
        out_valid_r <= 1'b0;
        out_imm_r   <= '0;
        out_tag_r   <= '0;
        out_type_r  <= 3'd0;
      end else if (flush) begin
        out_valid_r <= 1'b0;
      end else if (in_fire_s) begin
        out_valid_r <= 1'b1;
        out_imm_r   <= new_imm_s;
        out_tag_r   <= in_tag;
        out_type_r  <= in_type;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end else begin : g_skid
    logic             skid_valid_r;
    logic [XLEN-1:0]  skid_imm_r;
    logic [TAG_W-1:0] skid_tag_r;
    logic [2:0]       skid_type_r;
    logic             out_hold_s;

    // Accept only while the skid entry is free, so in_ready is a flop output.
    assign in_ready_s = ~skid_valid_r;
    assign out_hold_s = out_valid_r & ~out_ready;

    // Output register plus skid entry; the skid always holds the younger item.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
      if (!CPU_RST_N) begin
        out_valid_r  <= 1'b0;
        out_imm_r    <= '0;
        out_tag_r    <= '0;
        out_type_r   <= 3'd0;
        skid_valid_r <= 1'b0;
        skid_imm_r   <= '0;
        skid_tag_r   <= '0;
        skid_type_r  <= 3'd0;
      end else if (flush) begin
        out_valid_r  <= 1'b0;
        skid_valid_r <= 1'b0;
      end else if (out_hold_s) begin
        if (in_fire_s) begin
          skid_valid_r <= 1'b1;
          skid_imm_r   <= new_imm_s;
          skid_tag_r   <= in_tag;
          skid_type_r  <= in_type;
        end else begin
          skid_valid_r <= skid_valid_r;
        end
      end else if (skid_valid_r) begin
        out_valid_r  <= 1'b1;
        out_imm_r    <= skid_imm_r;
        out_tag_r    <= skid_tag_r;
        out_type_r   <= skid_type_r;
        skid_valid_r <= 1'b0;
      end else if (in_fire_s) begin
        out_valid_r <= 1'b1;
        out_imm_r   <= new_imm_s;
        out_tag_r   <= in_tag;
        out_type_r  <= in_type;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule
